// File: rtl/comp_two_decode_if.sv
// Handshake bundle for comp_two_decode: operand in, sign-magnitude result out.
// The slave modport is the decoder's view; master is the producer/consumer side.
interface comp_two_decode_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] IN_DATA;
  logic             IN_VALID;
  logic             IN_READY;
  logic             OUT_SIGN;
  logic [WIDTH-1:0] OUT_MAG;
  logic [WIDTH-1:0] OUT_PACKED;
  logic             OUT_OVF;
  logic             OUT_VALID;
  logic             OUT_READY;

  modport slave (
    input  IN_DATA,
    input  IN_VALID,
    input  OUT_READY,
    output IN_READY,
    output OUT_SIGN,
    output OUT_MAG,
    output OUT_PACKED,
    output OUT_OVF,
    output OUT_VALID
  );

  modport master (
    output IN_DATA,
    output IN_VALID,
    output OUT_READY,
    input  IN_READY,
    input  OUT_SIGN,
    input  OUT_MAG,
    input  OUT_PACKED,
    input  OUT_OVF,
    input  OUT_VALID
  );
endinterface

// File: rtl/comp_two_decode.sv
// comp_two_decode: two's-complement operand to sign-magnitude.
// Non-negative operands complete on the accept edge. Negative operands are
// negated bit-serially, LSB first (copy bits up to and including the first 1,
// invert the rest), taking WIDTH extra edges.
// Optional macro COMP_TWO_DECODE_FAST_EN: negate in parallel at the accept
// edge instead; the shift register and bit counter are then not built.
module comp_two_decode #(
  parameter int WIDTH = 8
) (
  input  logic              CLK,
  input  logic              RESET_N,
  comp_two_decode_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic             accept;
  logic             sign_r;
  logic             ovf_r;
  logic [WIDTH-1:0] mag_r;
  logic [WIDTH-1:0] packed_r;

  // Negative results: sign bit plus low magnitude bits; the most-negative
  // input has no representable magnitude and saturates to all ones.
  function automatic logic [WIDTH-1:0] sat_pack(input logic sign,
                                                input logic [WIDTH-1:0] mag);
    if (!sign)
      return mag;
    if (mag[WIDTH-1])
      return '1;
    return {1'b1, mag[WIDTH-2:0]};
  endfunction

  // A negative magnitude with its top bit set can only be 2^(WIDTH-1).
  function automatic logic is_ovf(input logic sign,
                                  input logic [WIDTH-1:0] mag);
    return sign & mag[WIDTH-1];
  endfunction

  assign accept = bus.IN_VALID && (state == IDLE);

`ifdef COMP_TWO_DECODE_FAST_EN
  logic [WIDTH-1:0] neg_mag;

  assign neg_mag = ~bus.IN_DATA + WIDTH'(1);
`else
  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [CNT_W-1:0] cnt;
  logic             seen_one;
  logic             res_bit;
  logic             shift_last;

  assign res_bit    = seen_one ? ~sreg[0] : sreg[0];
  assign acc_nxt    = {res_bit, acc[WIDTH-1:1]};
  assign shift_last = (state == SHIFT) && (cnt == CNT_W'(WIDTH - 1));

  // Serial negation engine: load on accept, one result bit per SHIFT edge.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sreg     <= '0;
      acc      <= '0;
      cnt      <= '0;
      seen_one <= 1'b0;
    end else if (accept) begin
      sreg     <= bus.IN_DATA;
      acc      <= '0;
      cnt      <= '0;
      seen_one <= 1'b0;
    end else if (state == SHIFT) begin
      sreg     <= sreg >> 1;
      acc      <= acc_nxt;
      seen_one <= seen_one | sreg[0];
      cnt      <= cnt + CNT_W'(1);
    end
  end
`endif

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic: IDLE -> (SHIFT ->) DONE -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef COMP_TWO_DECODE_FAST_EN
          state_nxt = DONE;
`else
          state_nxt = bus.IN_DATA[WIDTH-1] ? SHIFT : DONE;
`endif
        end
      end
      SHIFT: begin
`ifdef COMP_TWO_DECODE_FAST_EN
        state_nxt = IDLE;
`else
        if (shift_last)
          state_nxt = DONE;
`endif
      end
      DONE: begin
        if (bus.OUT_READY)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result registers: written only when a result is produced, so they hold
  // through DONE and keep their last value after the output handshake.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sign_r   <= 1'b0;
      mag_r    <= '0;
      packed_r <= '0;
      ovf_r    <= 1'b0;
    end else if (accept) begin
      sign_r <= bus.IN_DATA[WIDTH-1];
      if (!bus.IN_DATA[WIDTH-1]) begin
        mag_r    <= bus.IN_DATA;
        packed_r <= bus.IN_DATA;
        ovf_r    <= 1'b0;
      end
`ifdef COMP_TWO_DECODE_FAST_EN
      else begin
        mag_r    <= neg_mag;
        packed_r <= sat_pack(1'b1, neg_mag);
        ovf_r    <= is_ovf(1'b1, neg_mag);
      end
`else
    end else if (shift_last) begin
      mag_r    <= acc_nxt;
      packed_r <= sat_pack(1'b1, acc_nxt);
      ovf_r    <= is_ovf(1'b1, acc_nxt);
`endif
    end
  end

  assign bus.IN_READY   = (state == IDLE);
  assign bus.OUT_VALID  = (state == DONE);
  assign bus.OUT_SIGN   = sign_r;
  assign bus.OUT_MAG    = mag_r;
  assign bus.OUT_PACKED = packed_r;
  assign bus.OUT_OVF    = ovf_r;

endmodule
